// File: rtl/tlp_rp_pkg.sv
// Shared definitions for the root-port TX drain path: FIFO word layout,
// drain FSM encoding and widths.
package tlp_rp_pkg;
    localparam int RP_DATA_W = 128;
    localparam int RP_WORD_W = 131;
    localparam int RP_SOP    = 128;
    localparam int RP_EOP    = 129;
    localparam int RP_HALF   = 130;
    localparam int KEEP_W    = 16;
    localparam int BEAT_W    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } rpState_t;

    // Field order mirrors the FIFO bit positions above.
    typedef struct packed {
        logic                 half;
        logic                 eop;
        logic                 sop;
        logic [RP_DATA_W-1:0] data;
    } rpWord_t;

    function automatic logic [KEEP_W-1:0] rpKeep(input logic eop, input logic half);
        return (eop && half) ? 16'h00FF : 16'hFFFF;
    endfunction
endpackage

// File: rtl/tlp_skid2.sv
// Two-entry valid/ready buffer. When empty the input word is presented
// straight through and only captured if the sink stalls.
module tlp_skid2 import tlp_rp_pkg::*; #(
    parameter int W = RP_WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    input  logic [W-1:0] inData,
    output logic         outValid,
    output logic [W-1:0] outData,
    input  logic         outReady,
    output logic [1:0]   occ
);
    logic [W-1:0] q0, q1;
    logic         pop;

    assign outValid = (occ != 2'd0) || inValid;
    assign outData  = (occ != 2'd0) ? q0 : inData;
    assign pop      = outValid && outReady;

    // The writer guarantees no push into a full buffer without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= 2'd0;
        end else begin
            case (occ)
                2'd0: if (inValid && !pop) begin
                    q0  <= inData;
                    occ <= 2'd1;
                end
                2'd1: case ({inValid, pop})
                    2'b10: begin q1 <= inData; occ <= 2'd2; end
                    2'b01: occ <= 2'd0;
                    2'b11: q0 <= inData;
                    default: ;
                endcase
                default: if (pop) begin
                    q0 <= q1;
                    if (inValid) q1 <= inData;
                    else         occ <= 2'd1;
                end
            endcase
        end
    end
endmodule

// File: rtl/tlp_txrp_drain.sv
// Root-port TX drain: pulls whole TLPs from the RP FIFO under an arbiter
// grant and replays them onto the 128-bit TX stream.
module tlp_txrp_drain import tlp_rp_pkg::*; #(
    parameter int C_MAX_BEATS = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RP_WORD_W-1:0] TxRpFifoData,
    output logic                 TxRpFifoRdReq,
    input  logic                 RpTLPReady,
    output logic                 RpTxReq,
    input  logic                 RpTxGnt,
    output logic [RP_DATA_W-1:0] m_axis_rp_tdata,
    output logic [KEEP_W-1:0]    m_axis_rp_tkeep,
    output logic                 m_axis_rp_tlast,
    output logic                 m_axis_rp_tvalid,
    input  logic                 m_axis_rp_tready,
    output logic                 RpTxBusy,
    output logic                 RpTxErr
);
    rpState_t          state, stateNext;
    logic              rdPend, gotSop, discard, eopSeen, lastDone;
    logic [BEAT_W-1:0] beatCnt;
    logic              rdSop, rdEop, rdHalf;
    logic              dropWord, pushWord, overrun, retEop, tlastHs, done;
    rpWord_t           pushData, skidOut;
    logic              skidValid;
    logic [1:0]        occ;
    logic              unusedSop;

    assign rdSop     = TxRpFifoData[RP_SOP];
    assign rdEop     = TxRpFifoData[RP_EOP];
    assign rdHalf    = TxRpFifoData[RP_HALF];
    assign unusedSop = skidOut.sop;

    // Classify the word returning from the FIFO this cycle.
    always_comb begin
        dropWord = rdPend && !discard && !gotSop && !rdSop;
        pushWord = rdPend && !discard && (gotSop || rdSop);
        retEop   = rdPend && rdEop && (gotSop || rdSop || discard);
        overrun  = pushWord && !rdEop && (beatCnt == BEAT_W'(C_MAX_BEATS - 1));
        pushData = '{half: rdHalf && !overrun, eop: rdEop || overrun,
                     sop: rdSop, data: TxRpFifoData[RP_DATA_W-1:0]};
    end

    assign tlastHs = skidValid && m_axis_rp_tready && skidOut.eop;
    // Finished once the emitted tlast is gone and the FIFO is past the real eop.
    assign done    = (lastDone || tlastHs) && (eopSeen || retEop);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (RpTLPReady) stateNext = ST_REQ;
            ST_REQ:   if (RpTxGnt)    stateNext = ST_XFER;
            ST_XFER:  if (done)       stateNext = ST_IDLE;
                      else if (overrun || (pushWord && rdEop)) stateNext = ST_DRAIN;
            ST_DRAIN: if (done)       stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        RpTxReq       = (state != ST_IDLE);
        RpTxBusy      = (state != ST_IDLE);
        TxRpFifoRdReq = ((state == ST_XFER) || (state == ST_DRAIN)) && !eopSeen && !retEop
                        && ((occ + {1'b0, rdPend}) < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPend   <= 1'b0;
            gotSop   <= 1'b0;
            discard  <= 1'b0;
            eopSeen  <= 1'b0;
            lastDone <= 1'b0;
            beatCnt  <= '0;
            RpTxErr  <= 1'b0;
        end else begin
            rdPend  <= TxRpFifoRdReq;
            RpTxErr <= dropWord || overrun;
            if (state == ST_IDLE) begin
                gotSop   <= 1'b0;
                discard  <= 1'b0;
                eopSeen  <= 1'b0;
                lastDone <= 1'b0;
                beatCnt  <= '0;
            end else begin
                if (pushWord) begin
                    gotSop  <= 1'b1;
                    beatCnt <= beatCnt + 1'b1;
                end
                if (overrun) discard  <= 1'b1;
                if (retEop)  eopSeen  <= 1'b1;
                if (tlastHs) lastDone <= 1'b1;
            end
        end
    end

    tlp_skid2 #(.W(RP_WORD_W)) uSkid (
        .clk      (clk),
        .rst      (rst),
        .inValid  (pushWord),
        .inData   (pushData),
        .outValid (skidValid),
        .outData  (skidOut),
        .outReady (m_axis_rp_tready),
        .occ      (occ)
    );

    assign m_axis_rp_tvalid = skidValid;
    assign m_axis_rp_tdata  = skidValid ? skidOut.data : '0;
    assign m_axis_rp_tkeep  = skidValid ? rpKeep(skidOut.eop, skidOut.half) : '0;
    assign m_axis_rp_tlast  = skidValid && skidOut.eop;
endmodule

// File: tb/tb_tlp_txrp_drain.sv
// Directed bench for tlp_txrp_drain: FIFO and arbiter models, stream monitor,
// a vector table of TLP shapes plus a mid-TLP reset sequence.
module tb_tlp_txrp_drain;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [130:0] TxRpFifoData;
    logic         TxRpFifoRdReq, RpTLPReady, RpTxReq, RpTxGnt;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast, tvalid;
    logic         tready = 1'b1;
    logic         RpTxBusy, RpTxErr;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    tlp_txrp_drain #(.C_MAX_BEATS(34)) dut (
        .clk              (clk),
        .rst              (rst),
        .TxRpFifoData     (TxRpFifoData),
        .TxRpFifoRdReq    (TxRpFifoRdReq),
        .RpTLPReady       (RpTLPReady),
        .RpTxReq          (RpTxReq),
        .RpTxGnt          (RpTxGnt),
        .m_axis_rp_tdata  (tdata),
        .m_axis_rp_tkeep  (tkeep),
        .m_axis_rp_tlast  (tlast),
        .m_axis_rp_tvalid (tvalid),
        .m_axis_rp_tready (tready),
        .RpTxBusy         (RpTxBusy),
        .RpTxErr          (RpTxErr)
    );

    // FIFO model: one-cycle read latency, cleared by rst.
    logic [130:0] fifoQ[$];
    logic [130:0] fifoOut = '0;
    logic [130:0] popWord;
    logic         doRd, doRst;
    int           eopCnt = 0, underflow = 0;
    assign TxRpFifoData = fifoOut;
    assign RpTLPReady   = (eopCnt > 0);

    always @(posedge clk) begin
        doRd  = TxRpFifoRdReq;
        doRst = rst;
        #1;
        if (doRst) begin
            fifoQ.delete();
            eopCnt = 0;
        end else if (doRd) begin
            if (fifoQ.size() == 0) underflow++;
            else begin
                popWord = fifoQ.pop_front();
                fifoOut = popWord;
                if (popWord[129]) eopCnt--;
            end
        end
    end

    // Arbiter model: grant gntDly cycles after the request, held while requested.
    int gntDly = 0, reqAge = 0;
    always @(posedge clk) reqAge <= RpTxReq ? reqAge + 1 : 0;
    assign RpTxGnt = RpTxReq && (reqAge >= gntDly);

    int trMode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        tready = (trMode != 0) ? ~tready : 1'b1;
    end

    // Stream monitor.
    logic [127:0] capData[$];
    logic [15:0]  capKeep[$];
    logic         capLast[$];
    int           reqCycles = 0, errPulses = 0, badGnt = 0;
    logic         stallPrev = 1'b0;
    logic [144:0] stallWord;

    always @(negedge clk) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (RpTxReq) reqCycles++;
            if (RpTxErr) errPulses++;
            if ((TxRpFifoRdReq || tvalid) && !RpTxGnt) badGnt++;
            if (stallPrev) begin
                checks++;
                if (!tvalid || {tdata, tkeep, tlast} != stallWord) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %0h expected %0h", tvalid,
                             {tdata, tkeep, tlast}, stallWord);
                end
            end
            stallPrev = tvalid && !tready;
            stallWord = {tdata, tkeep, tlast};
            if (tvalid && tready) begin
                capData.push_back(tdata);
                capKeep.push_back(tkeep);
                capLast.push_back(tlast);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkData(input int v, input int i);
        return {v[31:0], i[31:0], 32'hC0DE_F00D, 32'(v * 1000 + i)};
    endfunction

    logic [127:0] expWords[$];

    task automatic clrStats();
        capData.delete();
        capKeep.delete();
        capLast.delete();
        reqCycles = 0;
        errPulses = 0;
        badGnt    = 0;
        underflow = 0;
    endtask

    task automatic pushTlp(input int v, input int n, input bit half, input bit bad);
        logic [130:0] w;
        expWords.delete();
        if (bad) begin
            w = {3'b000, mkData(v, 255)};
            fifoQ.push_back(w);
        end
        for (int i = 0; i < n; i++) begin
            w = {half && (i == n - 1), i == n - 1, i == 0, mkData(v, i)};
            fifoQ.push_back(w);
            expWords.push_back(mkData(v, i));
        end
        eopCnt++;
    endtask

    task automatic runTlp(input int v, input int expBeats, input int expErr,
                          input logic [15:0] expLastKeep, input int expReq);
        int t = 0;
        while (!RpTxBusy && t < 50) begin @(posedge clk); #1; t++; end
        while (RpTxBusy && t < 3000) begin @(posedge clk); #1; t++; end
        check($sformatf("v%0d_idle", v), RpTxBusy, 0);
        repeat (2) begin @(posedge clk); #1; end
        check($sformatf("v%0d_beats", v), capData.size(), expBeats);
        for (int i = 0; i < capData.size() && i < expBeats; i++) begin
            check($sformatf("v%0d_data%0d", v, i), capData[i], expWords[i]);
            check($sformatf("v%0d_keep%0d", v, i), capKeep[i],
                  (i == expBeats - 1) ? expLastKeep : 16'hFFFF);
            check($sformatf("v%0d_last%0d", v, i), capLast[i], i == expBeats - 1);
        end
        check($sformatf("v%0d_err", v), errPulses, expErr);
        check($sformatf("v%0d_gnt_order", v), badGnt, 0);
        check($sformatf("v%0d_fifo_left", v), fifoQ.size(), 0);
        check($sformatf("v%0d_underflow", v), underflow, 0);
        if (expReq > 0) check($sformatf("v%0d_req_cycles", v), reqCycles, expReq);
    endtask

    typedef struct {
        int          nBeats;
        bit          half;
        bit          badFirst;
        int          trMode;
        int          gntDly;
        int          expBeats;
        int          expErr;
        logic [15:0] expLastKeep;
        int          expReq;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3,  1'b0, 1'b0, 0, 0,  3,  0, 16'hFFFF, 5};
        vecs[1] = '{4,  1'b1, 1'b0, 1, 0,  4,  0, 16'h00FF, 0};
        vecs[2] = '{2,  1'b0, 1'b0, 0, 10, 2,  0, 16'hFFFF, 0};
        vecs[3] = '{40, 1'b0, 1'b0, 0, 0,  34, 1, 16'hFFFF, 0};
        vecs[4] = '{2,  1'b0, 1'b1, 0, 0,  2,  1, 16'hFFFF, 0};
        vecs[5] = '{1,  1'b1, 1'b0, 1, 3,  1,  0, 16'h00FF, 0};
        vecs[6] = '{34, 1'b0, 1'b0, 1, 0,  34, 0, 16'hFFFF, 0};
        vecs[7] = '{35, 1'b1, 1'b0, 0, 0,  34, 1, 16'hFFFF, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {tvalid, tlast, tkeep, TxRpFifoRdReq, RpTxReq, RpTxBusy, RpTxErr}, 0);
        check("reset_tdata", tdata, 0);
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        for (int v = 0; v < 8; v++) begin
            trMode = vecs[v].trMode;
            gntDly = vecs[v].gntDly;
            clrStats();
            pushTlp(v, vecs[v].nBeats, vecs[v].half, vecs[v].badFirst);
            runTlp(v, vecs[v].expBeats, vecs[v].expErr, vecs[v].expLastKeep, vecs[v].expReq);
        end

        // Reset while beat 2 of a 5-beat TLP is on the stream.
        trMode = 0;
        gntDly = 0;
        clrStats();
        pushTlp(20, 5, 1'b0, 1'b0);
        for (int t = 0; t < 50 && capData.size() < 1; t++) begin @(posedge clk); #1; end
        check("rst_beat1_seen", capData.size(), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_ctrl", {tvalid, tlast, tkeep, TxRpFifoRdReq, RpTxReq, RpTxBusy, RpTxErr}, 0);
        check("rst_tdata", tdata, 0);
        repeat (2) begin @(posedge clk); #1; end
        check("rst_stays_idle", {RpTxBusy, tvalid}, 0);
        clrStats();
        pushTlp(21, 3, 1'b0, 1'b0);
        runTlp(21, 3, 0, 16'hFFFF, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tlp_txrp_drain.md
# tlp_txrp_drain

Root-port transmit drain engine: consumes complete TLPs from the 131-bit root-port TLP FIFO, the reader end of the TxRpFifoData/TxRpFifoRdReq/RpTLPReady interface, and replays them onto the 128-bit PCIe TX AXI-stream toward the core. It holds a request to the TX arbiter for the duration of each TLP, absorbs sink backpressure through a 2-entry skid buffer, and aborts TLPs that run past a maximum beat count. It sits between the root-port FIFO and the TX arbiter in the axi_pcie TLP layer.

## Interface
- C_MAX_BEATS, 34: maximum beats per TLP, including header beats; a TLP beyond this is truncated.
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- TxRpFifoData  in  131  FIFO word: [127:0] data, [128] sop, [129] eop, [130] half (only [63:0] valid on an eop beat).
- TxRpFifoRdReq  out  1  FIFO read strobe; data is valid exactly 1 cycle later.
- RpTLPReady  in  1  FIFO holds at least one complete TLP.
- RpTxReq  out  1  request to TX arbiter.
- RpTxGnt  in  1  arbiter grant; sticky while RpTxReq is high.
- m_axis_rp_tdata  out  128  stream data.
- m_axis_rp_tkeep  out  16  byte enables: 16'hFFFF, or 16'h00FF on half eop beat.
- m_axis_rp_tlast  out  1  last beat of TLP.
- m_axis_rp_tvalid  out  1  beat valid.
- m_axis_rp_tready  in  1  sink ready.
- RpTxBusy  out  1  high from leaving IDLE until return to IDLE.
- RpTxErr  out  1  one-cycle pulse on abort (missing sop or beat overrun).

## Operation
- States: IDLE, REQ, XFER, DRAIN.
- IDLE: when RpTLPReady=1, go to REQ and raise RpTxReq.
- REQ: wait for RpTxGnt=1, then go to XFER.
- XFER: issue TxRpFifoRdReq when (skid occupancy + reads in flight) < 2 and the eop word has not yet been read. Stop reading once a word with eop=1 has been requested-and-returned.
- DRAIN: entered when the eop word enters the skid. Wait until the skid is empty and the last beat has handshaken, then drop RpTxReq and go to IDLE.
- Beat counter: 6 bits; increments per word read. When it reaches C_MAX_BEATS without eop:
  - force tlast on that beat;
  - pulse RpTxErr;
  - go to DRAIN.
  - Remaining words of that TLP are discarded afterward by reading until eop, with tvalid suppressed and the arbiter request held.
- First word of a TLP with sop=0: drop the word, pulse RpTxErr, keep reading until a sop word arrives. No output is produced for dropped words.
- Stream rules:
  - tvalid, once high, holds with stable data, tkeep and tlast until tready.
  - tkeep is 16'h00FF only when eop=1 and half=1.
- Reset values: all outputs 0, state IDLE, skid empty, counter 0.
- rst asserted mid-TLP: return to IDLE immediately. Any in-flight read data is discarded. The FIFO is reset by the same rst.

## Timing
- FIFO read latency is fixed at 1 cycle; the skid captures the word on the cycle after RdReq.
- Back-to-back reads sustain one beat per cycle while tready=1.
- With RpTLPReady already high, the first tvalid appears at the earliest 3 cycles after IDLE:
  - RpTxReq is registered;
  - the grant is seen;
  - RdReq is issued;
  - the data is registered.
- The skid never overflows: at most 2 words are held or in flight, and tready may drop at any cycle.
- RpTxReq falls on the cycle after the tlast handshake. A new TLP may raise RpTxReq again one cycle later (IDLE lasts 1 cycle).
- Grant arriving in the same cycle as the request: accepted. The REQ state lasts a minimum of 1 cycle.

## Structure
- Shared package tlp_rp_pkg holds:
  - FIFO field positions (RP_SOP=128, RP_EOP=129, RP_HALF=130);
  - state encoding;
  - width constants.
- Natural sub-module: tlp_skid2, a 2-entry valid/ready buffer with 131-bit payload and occupancy output. The read-credit logic uses that occupancy.

## Test plan
- Single 3-beat TLP (sop, mid, eop half=0) with tready=1 and gnt on request -> 3 beats back-to-back, tlast on beat 3, tkeep=FFFF, RpTxReq high 5 cycles total.
- 4-beat TLP with eop half=1 and tready toggling 1/0 each cycle -> data stable while stalled, last tkeep=16'h00FF, no word lost or duplicated.
- Grant delayed 10 cycles -> no TxRpFifoRdReq before grant, tvalid=0 throughout.
- 40-beat TLP with no eop until beat 40 and C_MAX_BEATS=34 -> 34 beats out with tlast on beat 34, RpTxErr pulse, words 35–40 read and discarded, then IDLE.
- First word with sop=0, followed by a valid 2-beat TLP -> RpTxErr pulse, only the 2-beat TLP appears on the stream.
- rst asserted on beat 2 of a 5-beat TLP -> next cycle all outputs 0 and state IDLE; a subsequent TLP transfers correctly.
